// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: 2-flop input synchronizer, mid-bit sampling, single-byte
// holding register with valid/ready handshake, framing-error and overrun pulses.
module uart_rx_byte #(
  parameter int   BAUD_DIV  = 417,
  parameter logic SYNC_INIT = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       framing_err,
  output logic       overrun
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(BAUD_DIV - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

  logic          sync1, rxs;
  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bitcnt, bitcnt_n;
  logic [7:0]    shreg, shreg_n;
  logic          deliver, ferr;
  logic          tick;

  assign tick = (cnt == '0);

  // Two-flop synchronizer; only rxs feeds any decision.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= SYNC_INIT;
      rxs   <= SYNC_INIT;
    end else begin
      sync1 <= rxd;
      rxs   <= sync1;
    end
  end

  // Frame state, baud/bit counters and shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      bitcnt <= '0;
      shreg  <= '0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      bitcnt <= bitcnt_n;
      shreg  <= shreg_n;
    end
  end

  // Next-state logic; sample points occur when the baud counter reaches zero.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    bitcnt_n = bitcnt;
    shreg_n  = shreg;
    deliver  = 1'b0;
    ferr     = 1'b0;
    case (state)
      IDLE: begin
        if (!rxs) begin
          cnt_n   = HALF;
          state_n = START;
        end
      end
      START: begin
        if (!tick) begin
          cnt_n = cnt - CW'(1);
        end else if (rxs) begin
          state_n = IDLE;             // false start, glitch shorter than half a bit
        end else begin
          cnt_n    = FULL;
          bitcnt_n = '0;
          state_n  = DATA;
        end
      end
      DATA: begin
        if (!tick) begin
          cnt_n = cnt - CW'(1);
        end else begin
          shreg_n  = {rxs, shreg[7:1]};
          cnt_n    = FULL;
          bitcnt_n = bitcnt + 3'd1;
          if (bitcnt == 3'd7) state_n = STOP;
        end
      end
      STOP: begin
        if (!tick) begin
          cnt_n = cnt - CW'(1);
        end else if (rxs) begin
          deliver = 1'b1;
          state_n = IDLE;             // back in IDLE right away so back-to-back frames work
        end else begin
          ferr    = 1'b1;
          state_n = BRK;
        end
      end
      BRK: begin
        if (rxs) state_n = IDLE;      // one framing error per held-low episode
      end
      default: state_n = IDLE;
    endcase
  end

  // Holding register, handshake and single-cycle status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      framing_err <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      framing_err <= ferr;
      overrun     <= 1'b0;
      if (deliver) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= shreg;
          rx_valid <= 1'b1;
        end else begin
          overrun  <= 1'b1;           // new byte dropped, held byte kept
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Self-checking bench for uart_rx_byte: directed frames plus randomized frames
// scored against a frame-level expected byte queue and flag counts.
module tb_uart_rx_byte;

  localparam int BD = 16;

  logic       clk = 1'b0;
  logic       rst, rxd, rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, framing_err, overrun;

  uart_rx_byte #(.BAUD_DIV(BD), .SYNC_INIT(1'b1)) dut (
    .clk(clk), .rst(rst), .rxd(rxd),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .framing_err(framing_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_rise = -1;
  int ferr_cycles = 0, ovr_cycles = 0;
  int exp_ferr = 0, exp_ovr = 0;
  logic prev_valid = 1'b0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Observer: transfers, flag cycles and rx_valid rising edges.
  always @(negedge clk) begin
    if (rx_valid && rx_ready) got_q.push_back(rx_data);
    if (framing_err) ferr_cycles++;
    if (overrun) ovr_cycles++;
    if (rx_valid && !prev_valid) last_rise = cyc;
    prev_valid = rx_valid;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic v, input int n);
    rxd = v;
    repeat (n) step();
  endtask

  task automatic send(input logic [7:0] b, input logic stop);
    hold(1'b0, BD);
    for (int i = 0; i < 8; i++) hold(b[i], BD);
    hold(stop, BD);
  endtask

  // Compare observed bytes and flag counts against the model, then clear both.
  task automatic check_seg(input string tag);
    chk({tag, "_nbytes"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk({tag, "_byte"}, got_q[i], exp_q[i]);
    chk({tag, "_ferr"}, ferr_cycles, exp_ferr);
    chk({tag, "_ovr"}, ovr_cycles, exp_ovr);
    got_q.delete(); exp_q.delete();
    ferr_cycles = 0; ovr_cycles = 0; exp_ferr = 0; exp_ovr = 0;
  endtask

  initial begin
    int t0;
    logic [7:0] b;
    logic bad;

    rst = 1'b1; rxd = 1'b1; rx_ready = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    chk("rst_valid", rx_valid, 0);
    chk("rst_data", rx_data, 0);
    chk("rst_ferr", framing_err, 0);
    chk("rst_ovr", overrun, 0);
    hold(1'b1, BD);

    // Single good frame with latency check.
    t0 = cyc;
    send(8'hA5, 1'b1);
    exp_q.push_back(8'hA5);
    hold(1'b1, 2 * BD);
    chk("lat_a5", last_rise - t0, (19 * BD) / 2 + 3);
    check_seg("a5");
    chk("hold_data", rx_data, 8'hA5);
    chk("hold_valid", rx_valid, 0);

    // Short low glitch: must be rejected.
    hold(1'b0, 5);
    hold(1'b1, 3 * BD);
    check_seg("glitch");

    // Bad stop bit followed by a held-low line, then recovery.
    send(8'h3C, 1'b0);
    hold(1'b0, 40);
    hold(1'b1, 2 * BD);
    exp_ferr = 1;
    check_seg("ferr");
    send(8'h42, 1'b1);
    exp_q.push_back(8'h42);
    hold(1'b1, 2 * BD);
    check_seg("after_ferr");

    // Overrun: consumer stalled across two frames.
    rx_ready = 1'b0;
    send(8'h11, 1'b1);
    hold(1'b1, BD);
    send(8'h22, 1'b1);
    hold(1'b1, 2 * BD);
    exp_ovr = 1;
    check_seg("ovr");
    chk("ovr_valid", rx_valid, 1);
    chk("ovr_data", rx_data, 8'h11);
    rx_ready = 1'b1;
    step();
    chk("ovr_clear", rx_valid, 0);
    exp_q.push_back(8'h11);
    check_seg("ovr_read");

    // Back-to-back frames with no idle gap.
    send(8'h00, 1'b1);
    send(8'hFF, 1'b1);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    hold(1'b1, 2 * BD);
    check_seg("b2b");

    // Reset in the middle of data bit 4; line returns to idle afterwards.
    hold(1'b0, BD);
    for (int i = 0; i < 4; i++) hold(1'b1, BD);
    hold(1'b0, BD / 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    rxd = 1'b1;
    chk("mrst_valid", rx_valid, 0);
    chk("mrst_data", rx_data, 0);
    chk("mrst_ferr", framing_err, 0);
    chk("mrst_ovr", overrun, 0);
    hold(1'b1, 12 * BD);
    send(8'h5A, 1'b1);
    exp_q.push_back(8'h5A);
    hold(1'b1, 2 * BD);
    check_seg("mrst");

    // Randomized frames, occasional bad stop bits, random idle gaps.
    for (int k = 0; k < 24; k++) begin
      b = 8'($urandom);
      bad = ($urandom_range(0, 5) == 0);
      send(b, !bad);
      if (bad) begin
        exp_ferr++;
        hold(1'b0, $urandom_range(0, 30));
        hold(1'b1, $urandom_range(3, 20));
      end else begin
        exp_q.push_back(b);
        hold(1'b1, $urandom_range(0, 20));
      end
    end
    hold(1'b1, 2 * BD);
    check_seg("rand");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
